// File: rtl/cam_dvp_emulator_pkg.sv
// Shared DVP camera geometry, pattern-mode encodings and helpers for the
// capture path and the synthetic camera source.
package cam_dvp_emulator_pkg;

  localparam int DVP_IMAGE_WIDTH     = 640;
  localparam int DVP_IMAGE_HEIGHT    = 480;
  localparam int DVP_FRAME_WIDTH     = 784;
  localparam int DVP_FRAME_HEIGHT    = 510;
  localparam int DVP_BYTES_PER_PIXEL = 2;
  localparam int DVP_VSYNC_LINES     = 3;
  localparam int DVP_V_START         = 17;

  localparam logic [7:0] DVP_CHROMA_NEUTRAL = 8'h80;

  typedef enum logic [1:0] {
    MODE_CONST = 2'd0,
    MODE_HRAMP = 2'd1,
    MODE_VRAMP = 2'd2,
    MODE_CHECK = 2'd3
  } pattern_mode_e;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FRAME = 1'b1
  } emu_state_e;

  // 8x8 checkerboard: bit 3 of each coordinate selects the tile colour.
  function automatic logic [7:0] checker_luma(input logic x_bit3, input logic y_bit3);
    return (x_bit3 ^ y_bit3) ? 8'hFF : 8'h00;
  endfunction

endpackage

// File: rtl/cam_dvp_emulator_pattern_gen.sv
// Combinational YUYV test-pattern byte generator: luma on even bytes,
// neutral chroma on odd bytes.
module dvp_pattern_gen
  import cam_dvp_emulator_pkg::*;
(
  input  pattern_mode_e mode_i,
  input  logic [7:0]    const_i,
  input  logic [7:0]    x_i,
  input  logic [7:0]    y_i,
  input  logic          odd_i,
  output logic [7:0]    byte_o
);

  always_comb begin
    byte_o = DVP_CHROMA_NEUTRAL;
    if (!odd_i) begin
      case (mode_i)
        MODE_CONST: byte_o = const_i;
        MODE_HRAMP: byte_o = x_i;
        MODE_VRAMP: byte_o = y_i;
        MODE_CHECK: byte_o = checker_luma(x_i[3], y_i[3]);
        default:    byte_o = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/cam_dvp_emulator.sv
// Synthetic OV7670-style DVP source: frame FSM, byte/line counters and
// registered pclk/vsync/href/data outputs, one pipeline clock behind the counters.
module cam_dvp_emulator
  import cam_dvp_emulator_pkg::*;
#(
  parameter int IMAGE_WIDTH     = DVP_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT    = DVP_IMAGE_HEIGHT,
  parameter int FRAME_WIDTH     = DVP_FRAME_WIDTH,
  parameter int FRAME_HEIGHT    = DVP_FRAME_HEIGHT,
  parameter int BYTES_PER_PIXEL = DVP_BYTES_PER_PIXEL,
  parameter int VSYNC_LINES     = DVP_VSYNC_LINES,
  parameter int V_START         = DVP_V_START
) (
  input  logic        clock,
  input  logic        n_rst,
  input  logic        in_enable,
  input  logic [1:0]  in_mode,
  input  logic [7:0]  in_const,
  output logic        out_pclk,
  output logic        out_vsync,
  output logic        out_href,
  output logic [7:0]  out_data,
  output logic        out_frame_done,
  output logic [15:0] out_frame_cnt
);

  localparam int BYTES_PER_LINE = BYTES_PER_PIXEL * FRAME_WIDTH;
  localparam int BW = $clog2(BYTES_PER_LINE + 1);
  localparam int LW = $clog2(FRAME_HEIGHT + 1);

  localparam logic [BW-1:0] B_LAST = BW'(BYTES_PER_LINE - 1);
  localparam logic [BW-1:0] B_ACT  = BW'(BYTES_PER_PIXEL * IMAGE_WIDTH);
  localparam logic [BW-1:0] B_BPP  = BW'(BYTES_PER_PIXEL);
  localparam logic [LW-1:0] L_LAST = LW'(FRAME_HEIGHT - 1);
  localparam logic [LW-1:0] L_VS   = LW'(VSYNC_LINES);
  localparam logic [LW-1:0] L_V0   = LW'(V_START);
  localparam logic [LW-1:0] L_V1   = LW'(V_START + IMAGE_HEIGHT);

  emu_state_e    state_q;
  logic          ph_q;
  logic [BW-1:0] b_q, b_d;
  logic [LW-1:0] l_q, l_d;
  pattern_mode_e mode_q, mode_eff;
  logic [7:0]    const_q, const_eff;

  logic          frame_start, b_wrap, frame_end;
  logic          vsync_d, href_d;
  logic [7:0]    x8, y8, pix;

  always_comb begin
    frame_start = (state_q == S_FRAME) && !ph_q && (b_q == '0) && (l_q == '0);
    b_wrap      = ph_q && (b_q == B_LAST);
    frame_end   = (state_q == S_FRAME) && b_wrap && (l_q == L_LAST);

    // The frame-start byte already uses the freshly sampled mode.
    mode_eff  = frame_start ? pattern_mode_e'(in_mode) : mode_q;
    const_eff = frame_start ? in_const : const_q;

    vsync_d = (l_q < L_VS);
    href_d  = (l_q >= L_V0) && (l_q < L_V1) && (b_q < B_ACT);
    x8      = 8'(b_q / B_BPP);
    y8      = 8'(l_q - L_V0);

    b_d = b_q;
    l_d = l_q;
    if (ph_q) begin
      if (b_wrap) begin
        b_d = '0;
        l_d = (l_q == L_LAST) ? '0 : l_q + 1'b1;
      end else begin
        b_d = b_q + 1'b1;
      end
    end
  end

  dvp_pattern_gen u_pattern (
    .mode_i  (mode_eff),
    .const_i (const_eff),
    .x_i     (x8),
    .y_i     (y8),
    .odd_i   (b_q[0]),
    .byte_o  (pix)
  );

  always_ff @(posedge clock) begin
    if (!n_rst) begin
      state_q        <= S_IDLE;
      ph_q           <= 1'b0;
      b_q            <= '0;
      l_q            <= '0;
      mode_q         <= MODE_CONST;
      const_q        <= 8'h00;
      out_pclk       <= 1'b0;
      out_vsync      <= 1'b0;
      out_href       <= 1'b0;
      out_data       <= 8'h00;
      out_frame_done <= 1'b0;
      out_frame_cnt  <= 16'h0000;
    end else begin
      out_frame_done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          ph_q      <= 1'b0;
          b_q       <= '0;
          l_q       <= '0;
          out_pclk  <= 1'b0;
          out_vsync <= 1'b0;
          out_href  <= 1'b0;
          out_data  <= 8'h00;
          if (in_enable) state_q <= S_FRAME;
        end
        S_FRAME: begin
          ph_q     <= ~ph_q;
          b_q      <= b_d;
          l_q      <= l_d;
          out_pclk <= ph_q;
          if (frame_start) begin
            mode_q  <= mode_eff;
            const_q <= const_eff;
          end
          // New byte presented as pclk falls; it holds through the following rise.
          if (!ph_q) begin
            out_vsync <= vsync_d;
            out_href  <= href_d;
            out_data  <= href_d ? pix : 8'h00;
          end
          if (frame_end) begin
            out_frame_done <= 1'b1;
            out_frame_cnt  <= out_frame_cnt + 1'b1;
            if (!in_enable) state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_dvp_emulator.sv
module tb_cam_dvp_emulator;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        in_enable;
  logic [1:0]  in_mode;
  logic [7:0]  in_const;
  logic        out_pclk, out_vsync, out_href, out_frame_done;
  logic [7:0]  out_data;
  logic [15:0] out_frame_cnt;

  logic        chk_en;
  logic [1:0]  chk_mode;
  logic [7:0]  chk_const;
  logic        c_pclk, c_vsync, c_href, c_done;
  logic [7:0]  c_data;
  logic [15:0] c_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cam_dvp_emulator #(
    .IMAGE_WIDTH(8), .IMAGE_HEIGHT(4), .FRAME_WIDTH(12), .FRAME_HEIGHT(8),
    .BYTES_PER_PIXEL(2), .VSYNC_LINES(1), .V_START(2)
  ) dut (
    .clock(clk), .n_rst(n_rst), .in_enable(in_enable), .in_mode(in_mode),
    .in_const(in_const), .out_pclk(out_pclk), .out_vsync(out_vsync),
    .out_href(out_href), .out_data(out_data), .out_frame_done(out_frame_done),
    .out_frame_cnt(out_frame_cnt)
  );

  cam_dvp_emulator #(
    .IMAGE_WIDTH(16), .IMAGE_HEIGHT(16), .FRAME_WIDTH(20), .FRAME_HEIGHT(18),
    .BYTES_PER_PIXEL(2), .VSYNC_LINES(1), .V_START(2)
  ) dut_chk (
    .clock(clk), .n_rst(n_rst), .in_enable(chk_en), .in_mode(chk_mode),
    .in_const(chk_const), .out_pclk(c_pclk), .out_vsync(c_vsync),
    .out_href(c_href), .out_data(c_data), .out_frame_done(c_done),
    .out_frame_cnt(c_cnt)
  );

  task automatic chk(input string tag, input int at, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s at=%0d observed=0x%0h expected=0x%0h", tag, at, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input int at, input logic [15:0] exp_cnt);
    chk({tag, "_pclk"},  at, 32'(out_pclk),       32'd0);
    chk({tag, "_vsync"}, at, 32'(out_vsync),      32'd0);
    chk({tag, "_href"},  at, 32'(out_href),       32'd0);
    chk({tag, "_data"},  at, 32'(out_data),       32'd0);
    chk({tag, "_done"},  at, 32'(out_frame_done), 32'd0);
    chk({tag, "_cnt"},   at, 32'(out_frame_cnt),  32'(exp_cnt));
  endtask

  initial begin
    int f, p, bb, ln, bi;
    logic       e_pclk, e_vs, e_href, e_done;
    logic [7:0] e_dat;
    logic [15:0] e_cnt;
    int vs_clks, href_bytes, href_lines;
    logic prev_href;

    n_rst = 1'b0; in_enable = 1'b1; in_mode = 2'd1; in_const = 8'h00;
    chk_en = 1'b1; chk_mode = 2'd3; chk_const = 8'h00;
    vs_clks = 0; href_bytes = 0; href_lines = 0; prev_href = 1'b0;

    // Reset held with enable high: everything quiet.
    repeat (5) @(posedge clk);
    #1;
    chk_idle("rst", 0, 16'h0000);

    n_rst = 1'b1;
    @(posedge clk); #1;
    chk("start_vsync_k0", 0, 32'(out_vsync), 32'd0);
    chk("start_pclk_k0",  0, 32'(out_pclk),  32'd0);

    // Four back-to-back frames: ramp, const 0x5A, ramp, vertical ramp, then stop.
    for (int k = 1; k <= 1540; k++) begin
      @(posedge clk); #1;
      if (k <= 1536) begin
        f  = (k - 1) / 384 + 1;
        p  = (k - 1) % 384;
        bb = p / 2;
        ln = bb / 24;
        bi = bb % 24;
        e_pclk = 1'(p % 2);
        e_vs   = (ln < 1);
        e_href = (ln >= 2) && (ln < 6) && (bi < 16);
        if (!e_href)          e_dat = 8'h00;
        else if (bi % 2 == 1) e_dat = 8'h80;
        else if (f == 2)      e_dat = 8'h5A;
        else if (f == 4)      e_dat = 8'(ln - 2);
        else                  e_dat = 8'(bi / 2);
        e_done = (p == 383);
        e_cnt  = 16'(f - 1 + ((p == 383) ? 1 : 0));
      end else begin
        e_pclk = 1'b0; e_vs = 1'b0; e_href = 1'b0; e_dat = 8'h00;
        e_done = 1'b0; e_cnt = 16'd4;
      end
      chk("pclk",  k, 32'(out_pclk),       32'(e_pclk));
      chk("vsync", k, 32'(out_vsync),      32'(e_vs));
      chk("href",  k, 32'(out_href),       32'(e_href));
      chk("data",  k, 32'(out_data),       32'(e_dat));
      chk("done",  k, 32'(out_frame_done), 32'(e_done));
      chk("cnt",   k, 32'(out_frame_cnt),  32'(e_cnt));

      if (k <= 384) begin
        if (out_vsync) vs_clks++;
        if (out_pclk) begin
          if (out_href) href_bytes++;
          if (out_href && !prev_href) href_lines++;
          prev_href = out_href;
        end
      end
      if (k == 384) begin
        chk("f1_vsync_clocks", k, 32'(vs_clks),    32'd48);
        chk("f1_href_bytes",   k, 32'(href_bytes), 32'd64);
        chk("f1_href_lines",   k, 32'(href_lines), 32'd4);
      end

      // Checkerboard instance (16x16 image, 40 bytes per line).
      if (k == 162) chk("chk_x0_y0", k, 32'(c_data), 32'h00);
      if (k == 194) chk("chk_x8_y0", k, 32'(c_data), 32'hFF);
      if (k == 196) chk("chk_x8_y0_chroma", k, 32'(c_data), 32'h80);
      if (k == 802) chk("chk_x0_y8", k, 32'(c_data), 32'hFF);
      if (k == 834) chk("chk_x8_y8", k, 32'(c_data), 32'h00);

      if (k == 10)   begin in_mode = 2'd0; in_const = 8'h5A; end
      if (k == 500)  in_mode = 2'd1;
      if (k == 900)  in_mode = 2'd2;
      if (k == 1300) in_enable = 1'b0;
    end

    // Restart, then reset during line 3 of the new frame.
    in_enable = 1'b1;
    @(posedge clk); #1;
    for (int j = 1; j <= 150; j++) begin
      @(posedge clk); #1;
    end
    chk("l3_pclk",  150, 32'(out_pclk),      32'd1);
    chk("l3_href",  150, 32'(out_href),      32'd1);
    chk("l3_data",  150, 32'(out_data),      32'h01);
    chk("l3_cnt",   150, 32'(out_frame_cnt), 32'd4);

    n_rst = 1'b0;
    for (int r = 1; r <= 3; r++) begin
      @(posedge clk); #1;
      chk_idle("midrst", r, 16'h0000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cam_dvp_emulator.md
# cam_dvp_emulator

Synthetic camera source that drives an OV7670-style DVP parallel interface (pixel clock, VSYNC, HREF, 8-bit data). It produces byte-serial YUYV test-pattern frames with the same frame geometry as the physical cameras. It sits in front of the camera capture path (`cam_top` → `simple_lsd` / `topview`) and replaces `pclk_f`/`href_f`/`vs_f`/`data_f`, so the line-detection and bird's-eye pipeline can be exercised in simulation or on the board without a sensor.

## Interface
- `IMAGE_WIDTH`, 640, active pixels per line
- `IMAGE_HEIGHT`, 480, active lines per frame
- `FRAME_WIDTH`, 784, total pixel periods per line, including blanking
- `FRAME_HEIGHT`, 510, total lines per frame
- `BYTES_PER_PIXEL`, 2, bytes per pixel (YUYV)
- `VSYNC_LINES`, 3, number of lines at frame start with VSYNC high
- `V_START`, 17, index of the first active line; `V_START+IMAGE_HEIGHT <= FRAME_HEIGHT` is required
- `clock` in 1: system clock (`clk_12m`)
- `n_rst` in 1: reset, synchronous, active-low
- `in_enable` in 1: run frames continuously while high
- `in_mode` in 2: pattern select; 0 constant, 1 horizontal ramp, 2 vertical ramp, 3 8×8 checkerboard
- `in_const` in 8: luma value used in mode 0
- `out_pclk` out 1: emulated pixel clock, equal to `clock`/2
- `out_vsync` out 1: frame sync, active high
- `out_href` out 1: active-byte qualifier
- `out_data` out 8: pixel byte
- `out_frame_done` out 1: one-cycle pulse at the end of each frame
- `out_frame_cnt` out 16: count of completed frames, wraps modulo 2^16

## Operation
- **FSM states:** IDLE and FRAME.
  - IDLE → FRAME when `in_enable` is sampled 1.
  - FRAME → IDLE at the frame end if `in_enable` is 0; otherwise FRAME → FRAME and a new frame starts.
  - Deasserting `in_enable` mid-frame has no effect until the frame end. Frames are never truncated.
- **Counters:**
  - Phase bit `ph` toggles every clock in FRAME; `out_pclk = ph`.
  - Byte counter `b` runs 0..BYTES_PER_PIXEL·FRAME_WIDTH−1 and line counter `l` runs 0..FRAME_HEIGHT−1.
  - `b` advances on cycles where `ph==1`; `l` advances when `b` wraps.
- **`out_vsync`:** 1 iff `l < VSYNC_LINES`.
- **`out_href`:** 1 iff `V_START <= l < V_START+IMAGE_HEIGHT` and `b < BYTES_PER_PIXEL·IMAGE_WIDTH`.
- **Pixel coordinates:** x = `b / BYTES_PER_PIXEL` (a shift when the parameter is a power of two), y = `l − V_START`.
- **`out_data` when `out_href`=1:**
  - Even `b` carries luma Y; odd `b` carries chroma, constant 0x80.
  - Y for mode 0 = `in_const`.
  - Y for mode 1 = x[7:0].
  - Y for mode 2 = y[7:0].
  - Y for mode 3 = 0xFF if x[3]^y[3], else 0x00.
- **`out_data` when `out_href`=0:** 0x00.
- **Mode latching:** `in_mode` and `in_const` are latched at frame start (cycle of l=0, b=0, ph=0). Changes mid-frame take effect at the next frame.
- **End of frame:** on the last byte of the last line with `ph==1`, `out_frame_done` pulses for one clock and `out_frame_cnt` increments. `out_frame_cnt` wraps 0xFFFF → 0x0000.
- **In IDLE:** `ph`, `b`, `l` are held at 0, and all DVP outputs are 0.

## Timing
- **Reset values:** every output is 0. The FSM is in IDLE and all counters are 0.
- **Reset mid-frame:** on the next clock every output is 0 and the FSM is in IDLE. No `out_frame_done` pulse and no count increment occur.
- **Start latency:** `in_enable` is sampled 1 at edge N. At edge N+1, `out_vsync`=1 with `out_pclk`=0; this is byte 0 of line 0.
- **Output registration:** `out_data`, `out_href` and `out_vsync` are registered and change only on edges where `out_pclk` goes 1→0. They are therefore stable for a full clock before and after each `out_pclk` rising edge.
- **Period lengths:**
  - One byte = 2 clocks.
  - One line = 2·BYTES_PER_PIXEL·FRAME_WIDTH clocks (3136 at defaults).
  - One frame = 1,599,360 clocks at defaults.
- **Back-to-back frames:** there is no gap; byte 0 of the next frame follows the last byte directly.

## Structure
- **Shared package:** DVP geometry constants (640/480/784/510, `VSYNC_LINES`, `V_START`), pattern-mode encodings, and the chroma constant 0x80. `cam_top` and this block use them.
- **Sub-module:** `dvp_pattern_gen`, a purely combinational block mapping (mode, const, x, y, byte parity) → byte.
- **Top of this block:** the FSM, counters and output registers.

## Test plan
All scenarios use small parameters: IMAGE 8×4, FRAME 12×8, BYTES_PER_PIXEL 2, VSYNC_LINES 1, V_START 2.
- **Reset values:** hold `n_rst`=0 for 5 clocks with `in_enable`=1 → all outputs 0. Release reset → `out_vsync`=1 two edges later, and `out_pclk` toggles each clock.
- **Frame geometry:** mode 1, one frame, capture on `out_pclk` rising edges →
  - exactly 4 lines have `out_href` high, each with 16 href bytes;
  - Y sequence per line is 0,1,…,7 and chroma is 0x80;
  - `out_vsync` is high for 48 clocks;
  - `out_frame_done` pulses at clock 384 of the frame.
- **Vertical ramp and checkerboard:** mode 2 → line y carries Y=y. Mode 3 with IMAGE 16×16 → Y=0xFF at x=8,y=0 and 0x00 at x=8,y=8.
- **Mode latching:** switch mode 0 (`in_const`=0x5A) → mode 1 mid-frame → all Y=0x5A in the current frame and a ramp in the next; the gap between frames is 0 clocks.
- **Stop at frame end:** drop `in_enable` mid-frame → the frame completes, `out_frame_cnt` increments by 1, then the FSM sits in IDLE with all outputs 0.
- **Reset mid-frame:** reset pulse during line 3 → all outputs 0 the next clock, `out_frame_cnt` is 0, and no `out_frame_done` pulse occurs.
